// File: rtl/ram_line_packer.sv
// Byte-stream to RAM line packer: gathers BEATS input beats into one LINE_W line
// and writes consecutive lines from a programmed base address.
module ram_line_packer #(
    parameter int LINE_W = 264,
    parameter int IN_W   = 8,
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_num_lines,
    input  logic              i_valid,
    input  logic [IN_W-1:0]   i_data,
    output logic              o_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [LINE_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BEATS = LINE_W / IN_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     beat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [LINE_W-1:0] line_q, line_nxt;
    logic              accept, last_beat;

    assign accept    = (state == FILL) && i_valid;
    assign last_beat = accept && (beat_cnt == BW'(BEATS - 1));

    // Control outputs decode straight from state so no input reaches an output.
    assign o_ready = (state == FILL);
    assign o_we    = (state == WRITE);
    assign o_busy  = (state == FILL) || (state == WRITE);
    assign o_done  = (state == DONE);

    always_comb begin
        line_nxt = line_q;
        line_nxt[beat_cnt*IN_W +: IN_W] = i_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (i_start) state_nxt = (i_num_lines == '0) ? DONE : FILL;
            FILL:  if (last_beat) state_nxt = WRITE;
            WRITE: state_nxt = (rem_q == (ADDR_W+1)'(1)) ? DONE : FILL;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            line_q   <= '0;
            o_addr   <= '0;
            o_data   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_start) begin
                addr_q <= i_base_addr;
                rem_q  <= i_num_lines;
            end
            if (accept) begin
                line_q   <= line_nxt;
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            // Output line is captured with the final beat so WRITE follows one cycle later
            // and o_addr/o_data stay stable while the next line is being filled.
            if (last_beat) begin
                o_data <= line_nxt;
                o_addr <= addr_q;
            end
            if (state == WRITE) begin
                addr_q <= addr_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_line_packer.sv
// Directed bench for ram_line_packer: table of load jobs plus a mid-job reset sequence.
module tb_ram_line_packer;

    localparam int LINE_W = 264;
    localparam int IN_W   = 8;
    localparam int ADDR_W = 11;
    localparam int BEATS  = LINE_W / IN_W;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              i_start = 0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [ADDR_W:0]   i_num_lines = '0;
    logic              i_valid = 0;
    logic [IN_W-1:0]   i_data = '0;
    logic              o_ready, o_we, o_busy, o_done;
    logic [ADDR_W-1:0] o_addr;
    logic [LINE_W-1:0] o_data;

    ram_line_packer #(.LINE_W(LINE_W), .IN_W(IN_W), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_lines(i_num_lines), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   num;
        bit                gap;
        bit                mid_start;
        logic [7:0]        seed;
    } job_t;

    job_t jobs[5];

    int n_vec = 0, n_bad = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, we_ready_bad = 0;
    logic [ADDR_W-1:0] wq_addr[$];
    logic [LINE_W-1:0] wq_data[$];
    int                wq_cyc[$];
    logic [7:0]        sent[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_we) begin
            wq_addr.push_back(o_addr);
            wq_data.push_back(o_data);
            wq_cyc.push_back(cyc);
            if (o_ready) we_ready_bad++;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [7:0] b, input bit gap);
        bit ok = 0;
        if (gap) begin
            i_valid = 0;
            i_data  = 8'hA5;
            step;
        end
        i_valid = 1;
        i_data  = b;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = o_ready;
            step;
        end
        if (!ok) chk("beat_accept_timeout", 0, 1);
        sent.push_back(b);
    endtask

    task automatic run_job(input job_t j);
        int s, base_dc, idx;
        logic [LINE_W-1:0] exp_line;
        logic [ADDR_W-1:0] ea;
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); sent.delete();
        base_dc = done_cnt;
        we_ready_bad = 0;
        i_base_addr = j.base;
        i_num_lines = j.num;
        i_start = 1;
        step;
        i_start = 0;
        s = cyc;
        if (j.num == 0) begin
            chk("zero_ready", o_ready, 0);
            chk("zero_done_now", o_done, 1);
        end
        idx = 0;
        for (int l = 0; l < int'(j.num); l++)
            for (int k = 0; k < BEATS; k++) begin
                if (j.mid_start && l == 0 && k == 10) begin
                    i_start = 1; i_base_addr = 7; i_num_lines = 5;
                end
                send_beat(j.seed + 8'(idx), j.gap);
                i_start = 0; i_base_addr = j.base; i_num_lines = j.num;
                idx++;
            end
        i_valid = 0;
        for (int t = 0; t < 20 && done_cnt == base_dc; t++) step;
        chk("done_seen", done_cnt - base_dc, 1);
        step;
        chk("done_once", done_cnt - base_dc, 1);
        chk("idle_busy", o_busy, 0);
        chk("idle_ready", o_ready, 0);
        chk("idle_we", o_we, 0);
        chk("nwrites", wq_addr.size(), j.num);
        chk("we_with_ready", we_ready_bad, 0);
        for (int i = 0; i < wq_addr.size() && i < int'(j.num); i++) begin
            ea = j.base + ADDR_W'(i);
            for (int k = 0; k < BEATS; k++) exp_line[k*8 +: 8] = sent[i*BEATS + k];
            chk($sformatf("addr[%0d]", i), wq_addr[i], ea);
            chk($sformatf("data[%0d]", i), wq_data[i], exp_line);
        end
        if (!j.gap) begin
            if (j.num != 0 && wq_cyc.size() > 0) chk("first_we_latency", wq_cyc[0] - s, BEATS);
            chk("done_latency", done_cyc - s, int'(j.num) * (BEATS + 1));
        end
    endtask

    initial begin
        int dc0;
        jobs[0] = '{base: 11'd5,    num: 12'd1, gap: 0, mid_start: 0, seed: 8'h00};
        jobs[1] = '{base: 11'd100,  num: 12'd2, gap: 1, mid_start: 0, seed: 8'h40};
        jobs[2] = '{base: 11'd2046, num: 12'd3, gap: 0, mid_start: 0, seed: 8'h11};
        jobs[3] = '{base: 11'd9,    num: 12'd0, gap: 0, mid_start: 0, seed: 8'h00};
        jobs[4] = '{base: 11'd300,  num: 12'd2, gap: 0, mid_start: 1, seed: 8'h80};

        step; step;
        chk("rst_ready", o_ready, 0);
        chk("rst_we", o_we, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_data", o_data, 0);
        rst_n = 1;
        step;

        for (int v = 0; v < 5; v++) run_job(jobs[v]);

        // Reset in the middle of filling the first line of a job.
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); sent.delete();
        dc0 = done_cnt;
        i_base_addr = 11'd50; i_num_lines = 12'd2; i_start = 1;
        step;
        i_start = 0;
        for (int k = 0; k < 10; k++) send_beat(8'(k), 0);
        chk("prereset_busy", o_busy, 1);
        #2 rst_n = 0;
        #1;
        chk("midrst_ready", o_ready, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_we", o_we, 0);
        chk("midrst_addr", o_addr, 0);
        chk("midrst_data", o_data, 0);
        for (int k = 0; k < 3; k++) step;
        rst_n = 1;
        for (int k = 0; k < 40; k++) step;
        i_valid = 0;
        chk("midrst_no_write", wq_addr.size(), 0);
        chk("midrst_no_done", done_cnt - dc0, 0);
        chk("postrst_idle_busy", o_busy, 0);

        run_job(jobs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
